// File: rtl/fpu_cmd_seq.sv
// Command sequencer in front of the combinational bf16 fpu: buffers commands, issues one per
// cycle, registers each result on a valid/ready port, and tracks overflow and issue count.
module fpu_cmd_seq #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             cmd_valid_i,
   output logic             cmd_ready_o,
   input  logic [3:0]       cmd_op_i,
   input  logic [15:0]      cmd_in1_i,
   input  logic [15:0]      cmd_in2_i,
   input  logic             cmd_chain_i,
   output logic [3:0]       fpu_op_o,
   output logic [15:0]      fpu_in1_o,
   output logic [15:0]      fpu_in2_o,
   input  logic [15:0]      fpu_out_i,
   input  logic             fpu_overflow_i,
   output logic             res_valid_o,
   input  logic             res_ready_i,
   output logic [15:0]      res_data_o,
   output logic             res_overflow_o,
   input  logic             clr_i,
   output logic             ovf_sticky_o,
   output logic [CNT_W-1:0] issued_cnt_o,
   output logic             busy_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   typedef struct packed {
      logic [3:0]  op;
      logic [15:0] in1;
      logic [15:0] in2;
      logic        chain;
   } cmd_t;

   cmd_t             mem [DEPTH];
   cmd_t             head;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic [15:0]      last_res;
   logic             fifo_empty;
   logic             push;
   logic             issue;

   // Both ports: a transfer happens on the rising edge where valid && ready are high; the
   // producer holds valid and payload stable until then, and ready never depends on valid.
   assign fifo_empty  = (count == '0);
   assign cmd_ready_o = rst_ni && (count != FULL_CNT);
   assign push        = cmd_valid_i && cmd_ready_o;
   assign issue       = rst_ni && !fifo_empty && (!res_valid_o || res_ready_i);
   assign head        = mem[rd_ptr];
   assign busy_o      = !fifo_empty || res_valid_o;

   // The fpu sees zeros whenever nothing is issuing so its inputs are never undefined.
   always_comb begin
      fpu_op_o  = '0;
      fpu_in1_o = '0;
      fpu_in2_o = '0;
      if (issue) begin
         fpu_op_o  = head.op;
         fpu_in1_o = head.chain ? last_res : head.in1;
         fpu_in2_o = head.in2;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr] <= '{op: cmd_op_i, in1: cmd_in1_i, in2: cmd_in2_i, chain: cmd_chain_i};
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         last_res       <= '0;
         res_valid_o    <= 1'b0;
         res_data_o     <= '0;
         res_overflow_o <= 1'b0;
         ovf_sticky_o   <= 1'b0;
         issued_cnt_o   <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (issue) rd_ptr <= rd_ptr + PTR_W'(1);

         case ({push, issue})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase

         if (issue) begin
            res_valid_o    <= 1'b1;
            res_data_o     <= fpu_out_i;
            res_overflow_o <= fpu_overflow_i;
            last_res       <= fpu_out_i;
         end else if (res_valid_o && res_ready_i) begin
            res_valid_o <= 1'b0;
         end

         // A same-cycle overflow wins over clear so no overflow event is ever lost.
         if (issue && fpu_overflow_i) ovf_sticky_o <= 1'b1;
         else if (clr_i)              ovf_sticky_o <= 1'b0;

         if (clr_i)      issued_cnt_o <= issue ? CNT_W'(1) : '0;
         else if (issue) issued_cnt_o <= issued_cnt_o + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_fpu_cmd_seq.sv
// Directed bench for fpu_cmd_seq with a small table-driven stand-in for the combinational fpu.
module tb_fpu_cmd_seq;

   localparam int DEPTH = 4;
   localparam int CNT_W = 16;
   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_MUL = 4'h1;
   localparam logic [3:0] OP_XOR = 4'h2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [3:0]       cmd_op;
   logic [15:0]      cmd_in1;
   logic [15:0]      cmd_in2;
   logic             cmd_chain;
   logic [3:0]       fpu_op;
   logic [15:0]      fpu_in1;
   logic [15:0]      fpu_in2;
   logic [15:0]      fpu_out;
   logic             fpu_ovf;
   logic             res_valid;
   logic             res_ready;
   logic [15:0]      res_data;
   logic             res_ovf;
   logic             clr;
   logic             ovf_sticky;
   logic [CNT_W-1:0] issued_cnt;
   logic             busy;

   int n_checks = 0;
   int n_errors = 0;
   logic [16:0] exp_q[$];
   logic [16:0] exp_item;

   fpu_cmd_seq #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
      .cmd_in1_i(cmd_in1), .cmd_in2_i(cmd_in2), .cmd_chain_i(cmd_chain),
      .fpu_op_o(fpu_op), .fpu_in1_o(fpu_in1), .fpu_in2_o(fpu_in2),
      .fpu_out_i(fpu_out), .fpu_overflow_i(fpu_ovf),
      .res_valid_o(res_valid), .res_ready_i(res_ready), .res_data_o(res_data),
      .res_overflow_o(res_ovf), .clr_i(clr), .ovf_sticky_o(ovf_sticky),
      .issued_cnt_o(issued_cnt), .busy_o(busy)
   );

   always #5 clk = ~clk;

   // Stand-in fpu: exact bf16 results for the vectors used here, XOR for the bulk-traffic op.
   always_comb begin
      fpu_out = fpu_in1 ^ fpu_in2;
      fpu_ovf = 1'b0;
      if (fpu_op == OP_ADD && fpu_in1 == 16'h3F80 && fpu_in2 == 16'h4000) fpu_out = 16'h4040;
      if (fpu_op == OP_ADD && fpu_in1 == 16'h3F80 && fpu_in2 == 16'h3F80) fpu_out = 16'h4000;
      if (fpu_op == OP_ADD && fpu_in1 == 16'h4000 && fpu_in2 == 16'h3F80) fpu_out = 16'h4040;
      if (fpu_op == OP_MUL && fpu_in1 == 16'h7F7F && fpu_in2 == 16'h4000) begin
         fpu_out = 16'h7F80;
         fpu_ovf = 1'b1;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic drive_cmd(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                            input logic chain);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_in1   = a;
      cmd_in2   = b;
      cmd_chain = chain;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; res_ready = 1'b1; clr = 1'b0;
      drive_cmd(OP_ADD, 16'h3F80, 16'h4000, 1'b0);

      // reset held with a valid command offered
      tick();
      for (int i = 0; i < 3; i++) begin
         check_eq("rst_cmd_ready", 32'(cmd_ready), 32'h0);
         check_eq("rst_res_valid", 32'(res_valid), 32'h0);
         check_eq("rst_busy", 32'(busy), 32'h0);
         check_eq("rst_fpu_in1", 32'(fpu_in1), 32'h0);
         tick();
      end
      check_eq("rst_issued_cnt", 32'(issued_cnt), 32'h0);
      check_eq("rst_sticky", 32'(ovf_sticky), 32'h0);
      check_eq("rst_res_data", 32'(res_data), 32'h0);
      rst_n = 1'b1;
      cmd_valid = 1'b0;
      tick();

      // single ADD, latency accept -> issue -> result
      drive_cmd(OP_ADD, 16'h3F80, 16'h4000, 1'b0);
      check_eq("t2_cmd_ready", 32'(cmd_ready), 32'h1);
      tick();
      cmd_valid = 1'b0;
      check_eq("t2_issue_in1", 32'(fpu_in1), 32'h3F80);
      check_eq("t2_issue_in2", 32'(fpu_in2), 32'h4000);
      check_eq("t2_early_valid", 32'(res_valid), 32'h0);
      tick();
      check_eq("t2_res_valid", 32'(res_valid), 32'h1);
      check_eq("t2_res_data", 32'(res_data), 32'h4040);
      check_eq("t2_res_ovf", 32'(res_ovf), 32'h0);
      check_eq("t2_issued_cnt", 32'(issued_cnt), 32'h1);
      tick();
      check_eq("t2_consumed", 32'(res_valid), 32'h0);
      check_eq("t2_idle_busy", 32'(busy), 32'h0);
      check_eq("t2_idle_fpu_in1", 32'(fpu_in1), 32'h0);

      // chaining: second command uses the first result as operand 1
      drive_cmd(OP_ADD, 16'h3F80, 16'h3F80, 1'b0);
      tick();
      drive_cmd(OP_ADD, 16'h1234, 16'h3F80, 1'b1);
      check_eq("t3_first_in1", 32'(fpu_in1), 32'h3F80);
      tick();
      cmd_valid = 1'b0;
      check_eq("t3_chain_in1", 32'(fpu_in1), 32'h4000);
      check_eq("t3_res1", 32'(res_data), 32'h4000);
      tick();
      check_eq("t3_res2", 32'(res_data), 32'h4040);
      check_eq("t3_res2_valid", 32'(res_valid), 32'h1);
      check_eq("t3_issued_cnt", 32'(issued_cnt), 32'h3);
      tick();
      check_eq("t3_consumed", 32'(res_valid), 32'h0);

      // backpressure: DEPTH+1 commands, one issued and DEPTH buffered
      res_ready = 1'b0;
      for (int i = 0; i < DEPTH + 1; i++) begin
         drive_cmd(OP_XOR, 16'h1100 + 16'(i), 16'h00F0, 1'b0);
         exp_q.push_back({1'b0, 16'h11F0 + 16'(i)});
         check_eq("t4_accept", 32'(cmd_ready), 32'h1);
         tick();
      end
      cmd_valid = 1'b0;
      check_eq("t4_full_ready", 32'(cmd_ready), 32'h0);
      check_eq("t4_one_issued", 32'(issued_cnt), 32'h4);
      check_eq("t4_busy", 32'(busy), 32'h1);
      tick();
      check_eq("t4_stall_data", 32'(res_data), 32'h11F0);
      check_eq("t4_stall_ready", 32'(cmd_ready), 32'h0);
      for (int k = 0; k < DEPTH + 1; k++) begin
         exp_item = exp_q.pop_front();
         check_eq("t4_drain_valid", 32'(res_valid), 32'h1);
         check_eq("t4_drain_data", 32'(res_data), 32'(exp_item[15:0]));
         check_eq("t4_drain_ovf", 32'(res_ovf), 32'(exp_item[16]));
         res_ready = 1'b1;
         tick();
      end
      check_eq("t4_drained", 32'(res_valid), 32'h0);
      check_eq("t4_issued_cnt", 32'(issued_cnt), 32'h8);
      check_eq("t4_idle_busy", 32'(busy), 32'h0);

      // overflow, sticky flag, clear interactions
      drive_cmd(OP_MUL, 16'h7F7F, 16'h4000, 1'b0);
      tick();
      cmd_valid = 1'b0;
      tick();
      check_eq("t5_res_ovf", 32'(res_ovf), 32'h1);
      check_eq("t5_res_data", 32'(res_data), 32'h7F80);
      check_eq("t5_sticky", 32'(ovf_sticky), 32'h1);
      check_eq("t5_issued_cnt", 32'(issued_cnt), 32'h9);
      tick();
      drive_cmd(OP_MUL, 16'h7F7F, 16'h4000, 1'b0);
      tick();
      cmd_valid = 1'b0;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check_eq("t5_clr_set_sticky", 32'(ovf_sticky), 32'h1);
      check_eq("t5_clr_issue_cnt", 32'(issued_cnt), 32'h1);
      check_eq("t5_res_ovf2", 32'(res_ovf), 32'h1);
      tick();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check_eq("t5_clr_sticky", 32'(ovf_sticky), 32'h0);
      check_eq("t5_clr_cnt", 32'(issued_cnt), 32'h0);

      // reset with three queued commands and a pending result
      res_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive_cmd(OP_XOR, 16'h2200 + 16'(i), 16'h0011, 1'b0);
         tick();
      end
      cmd_valid = 1'b0;
      check_eq("t6_pre_valid", 32'(res_valid), 32'h1);
      check_eq("t6_pre_busy", 32'(busy), 32'h1);
      rst_n = 1'b0;
      tick();
      check_eq("t6_rst_valid", 32'(res_valid), 32'h0);
      check_eq("t6_rst_busy", 32'(busy), 32'h0);
      check_eq("t6_rst_ready", 32'(cmd_ready), 32'h0);
      rst_n = 1'b1;
      res_ready = 1'b1;
      tick();
      tick();
      check_eq("t6_no_stale_valid", 32'(res_valid), 32'h0);
      check_eq("t6_no_stale_cnt", 32'(issued_cnt), 32'h0);
      drive_cmd(OP_XOR, 16'hAAAA, 16'h00FF, 1'b1);
      tick();
      cmd_valid = 1'b0;
      check_eq("t6_chain_after_rst", 32'(fpu_in1), 32'h0);
      tick();
      check_eq("t6_chain_res", 32'(res_data), 32'h00FF);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
